// File: rtl/decode_rename_queue.sv
// WAY-wide in-order circular queue between decode and rename, with partial accept and flush.
// Optional same-cycle bypass of incoming slots into empty out slots: define DECODE_RENAME_BYPASS_EN.
module decode_rename_queue #(
    parameter int unsigned WAY   = 2,
    parameter int unsigned DW    = 165,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic [WAY-1:0]               i_in_valid,
    input  logic [WAY*DW-1:0]            i_in_data,
    output logic                         o_in_ready,
    output logic [WAY-1:0]               o_out_valid,
    output logic [WAY*DW-1:0]            o_out_data,
    input  logic [$clog2(WAY+1)-1:0]     i_out_accept,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    int unsigned w_cnt;
    int unsigned w_free;
    int unsigned w_nin;
    int unsigned w_nin_eff;
    int unsigned w_nbyp;
    int unsigned w_nstore_vis;
    int unsigned w_nvis;
    int unsigned w_acc;
    int unsigned w_nacc;
    int unsigned w_nsacc;
    int unsigned w_skip;
    logic        w_run;

    assign w_cnt      = 32'(r_count);
    assign w_free     = DEPTH - w_cnt;
    assign o_in_ready = (w_free >= WAY);
    assign o_count    = r_count;
    assign w_acc      = 32'(i_out_accept);

    // Only the contiguous run of valids starting at slot 0 counts.
    always_comb begin
        w_nin = 0;
        w_run = 1'b1;
        for (int unsigned i = 0; i < WAY; i++) begin
            if (w_run && i_in_valid[i]) begin
                w_nin = w_nin + 1;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign w_nin_eff = o_in_ready ? w_nin : 0;

`ifdef DECODE_RENAME_BYPASS_EN
    always_comb begin
        w_nbyp = 0;
        if (w_cnt < WAY && !i_flush) begin
            w_nbyp = (w_nin_eff < WAY - w_cnt) ? w_nin_eff : (WAY - w_cnt);
        end
    end
`else
    assign w_nbyp = 0;
`endif

    assign w_nstore_vis = (w_cnt < WAY) ? w_cnt : WAY;
    assign w_nvis       = w_nstore_vis + w_nbyp;
    assign w_nacc       = (w_acc < w_nvis) ? w_acc : w_nvis;
    assign w_nsacc      = (w_nacc < w_cnt) ? w_nacc : w_cnt;
    // Incoming slots consumed straight from the bypass are never written to storage.
    assign w_skip       = w_nacc - w_nsacc;

    always_comb begin
        o_out_valid = '0;
        o_out_data  = '0;
        for (int unsigned j = 0; j < WAY; j++) begin
            o_out_data[j*DW +: DW] = r_mem[r_head + PW'(j)];
            if (j < w_cnt) begin
                o_out_valid[j] = 1'b1;
            end else if (j < w_cnt + w_nbyp) begin
                o_out_valid[j]         = 1'b1;
                o_out_data[j*DW +: DW] = i_in_data[(j - w_cnt)*DW +: DW];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_nsacc);
            r_tail  <= r_tail + PW'(w_nin_eff - w_skip);
            r_count <= CW'(w_cnt + w_nin_eff - w_nacc);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_flush) begin
            for (int unsigned i = 0; i < WAY; i++) begin
                if (i >= w_skip && i < w_nin_eff) begin
                    r_mem[r_tail + PW'(i - w_skip)] <= i_in_data[i*DW +: DW];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            assert (w_cnt <= DEPTH)
            else $error("decode_rename_queue: occupancy %0d exceeds depth", w_cnt);
            if (w_nvis != 0 && w_acc > w_nvis) begin
                $warning("decode_rename_queue: out_accept %0d above %0d valid slots", w_acc, w_nvis);
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_rename_queue.sv
// Scoreboard bench for decode_rename_queue (WAY=2, DEPTH=8); honours DECODE_RENAME_BYPASS_EN.
module tb_decode_rename_queue;
    localparam int WAY   = 2;
    localparam int DW    = 165;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [WAY-1:0]    in_valid;
    logic [WAY*DW-1:0] in_data;
    logic              in_ready;
    logic [WAY-1:0]    out_valid;
    logic [WAY*DW-1:0] out_data;
    logic [1:0]        out_accept;
    logic [3:0]        count;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb[$];

    decode_rename_queue #(.WAY(WAY), .DW(DW), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .i_out_accept(out_accept),
        .o_count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pay(input int id);
        logic [31:0] u;
        u = id;
        return {u, ~u, u ^ 32'hA5A5_A5A5, u + 32'd1, u * 32'd3, u[4:0]};
    endfunction

    task automatic set_in(input logic [1:0] v, input int id0, input int id1, input int acc,
                          input logic fl);
        in_valid   = v;
        in_data    = {pay(id1), pay(id0)};
        out_accept = 2'(acc);
        flush      = fl;
    endtask

    // Reference queue update for the inputs currently driven, then one clock.
    task automatic advance();
        int  n;
        int  vis;
        int  nacc;
        bit  rdy;
        n   = in_valid[0] ? (in_valid[1] ? 2 : 1) : 0;
        rdy = (DEPTH - sb.size()) >= WAY;
        if (!rdy) n = 0;
        if (flush) begin
            sb.delete();
        end else begin
            vis = (sb.size() > WAY) ? WAY : sb.size();
`ifdef DECODE_RENAME_BYPASS_EN
            if (sb.size() < WAY) vis = (sb.size() + n > WAY) ? WAY : sb.size() + n;
`endif
            nacc = (int'(out_accept) > vis) ? vis : int'(out_accept);
            for (int i = 0; i < n; i++) sb.push_back(in_data[i*DW +: DW]);
            repeat (nacc) void'(sb.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(2'b00, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid got %b want 00", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        set_in(2'b11, 1, 2, 0, 1'b0); advance();
        set_in(2'b11, 3, 4, 0, 1'b0); advance();
        set_in(2'b01, 5, 0, 0, 1'b0); advance();
        set_in(2'b00, 0, 0, 0, 1'b0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL pre_reset_count got %0d want 5", count); end
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL async_reset_count got %0d want 0", count); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL async_reset_valid got %b want 00", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_fill();
        for (int g = 0; g < 4; g++) begin
            set_in(2'b11, 100 + 2 * g, 101 + 2 * g, 0, 1'b0);
            advance();
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d want 8", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        set_in(2'b11, 200, 201, 0, 1'b0);
        advance();
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_ignore_count got %0d want 8", count); end
        checks++; if (out_data[DW-1:0] !== pay(100)) begin errors++; $display("FAIL fill_slot0 got %h want %h", out_data[DW-1:0], pay(100)); end
        checks++; if (out_data[2*DW-1:DW] !== pay(101)) begin errors++; $display("FAIL fill_slot1 got %h want %h", out_data[2*DW-1:DW], pay(101)); end
        set_in(2'b00, 0, 0, 0, 1'b1);
        advance();
        set_in(2'b00, 0, 0, 0, 1'b0);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL fill_flush_count got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        int  next_id = 0;
        int  got     = 0;
        int  cyc     = 0;
        int  rem;
        logic [1:0] v;
        bit  rdy;
        bit  has;
        while (got < 24 && cyc < 200) begin
            rem = 24 - next_id;
            v   = (rem >= 2) ? 2'b11 : ((rem == 1) ? 2'b01 : 2'b00);
            set_in(v, next_id, next_id + 1, 1, 1'b0);
            #1;
            rdy = (DEPTH - sb.size()) >= WAY;
            has = sb.size() > 0;
`ifdef DECODE_RENAME_BYPASS_EN
            if (v != 2'b00) has = 1'b1;
`endif
            checks++; if (count !== 4'(sb.size())) begin errors++; $display("FAIL wrap_count got %0d want %0d", count, sb.size()); end
            checks++; if (in_ready !== rdy) begin errors++; $display("FAIL wrap_in_ready got %b want %b", in_ready, rdy); end
            if (has) begin
                checks++;
                if (out_valid[0] !== 1'b1 || out_data[DW-1:0] !== pay(got)) begin
                    errors++;
                    $display("FAIL wrap_order valid %b data %h want item %0d (%h)", out_valid[0], out_data[DW-1:0], got, pay(got));
                end
                got++;
            end
            advance();
            if (rdy) next_id += (v == 2'b11) ? 2 : ((v == 2'b01) ? 1 : 0);
            cyc++;
        end
        set_in(2'b00, 0, 0, 0, 1'b0);
        checks++; if (got != 24) begin errors++; $display("FAIL wrap_timeout got %0d items want 24", got); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_drained got %0d want 0", count); end
    endtask

    task automatic test_simultaneous();
        set_in(2'b00, 0, 0, 0, 1'b1); advance();
        set_in(2'b11, 10, 11, 0, 1'b0); advance();
        set_in(2'b01, 12, 0, 0, 1'b0); advance();
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL sim_count3 got %0d want 3", count); end
        set_in(2'b11, 13, 14, 2, 1'b0);
        #1;
        checks++; if (out_data[DW-1:0] !== pay(10)) begin errors++; $display("FAIL sim_slot0_A got %h want %h", out_data[DW-1:0], pay(10)); end
        checks++; if (out_data[2*DW-1:DW] !== pay(11)) begin errors++; $display("FAIL sim_slot1_B got %h want %h", out_data[2*DW-1:DW], pay(11)); end
        advance();
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL sim_count_after got %0d want 3", count); end
        checks++; if (out_data[DW-1:0] !== pay(12)) begin errors++; $display("FAIL sim_slot0_C got %h want %h", out_data[DW-1:0], pay(12)); end
        checks++; if (out_data[2*DW-1:DW] !== pay(13)) begin errors++; $display("FAIL sim_slot1_D got %h want %h", out_data[2*DW-1:DW], pay(13)); end
        set_in(2'b01, 15, 0, 3, 1'b0);
        advance();
        set_in(2'b00, 0, 0, 0, 1'b0);
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL clamp_count got %0d want 2", count); end
        checks++; if (out_data[DW-1:0] !== pay(14)) begin errors++; $display("FAIL clamp_slot0 got %h want %h", out_data[DW-1:0], pay(14)); end
        checks++; if (out_data[2*DW-1:DW] !== pay(15)) begin errors++; $display("FAIL clamp_slot1 got %h want %h", out_data[2*DW-1:DW], pay(15)); end
    endtask

    task automatic test_noncontig_flush();
        set_in(2'b00, 0, 0, 0, 1'b1); advance();
        set_in(2'b10, 20, 21, 0, 1'b0);
        #1;
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL noncontig_valid got %b want 00", out_valid); end
        advance();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL noncontig_count got %0d want 0", count); end
        for (int g = 0; g < 3; g++) begin
            set_in(2'b11, 30 + 2 * g, 31 + 2 * g, 0, 1'b0);
            advance();
        end
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL preflush_count got %0d want 6", count); end
        set_in(2'b11, 40, 41, 2, 1'b1);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        advance();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got %b want 00", out_valid); end
        set_in(2'b11, 50, 51, 0, 1'b0);
        advance();
        set_in(2'b00, 0, 0, 0, 1'b0);
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL postflush_count got %0d want 2", count); end
        checks++; if (out_data[DW-1:0] !== pay(50)) begin errors++; $display("FAIL postflush_slot0 got %h want %h", out_data[DW-1:0], pay(50)); end
    endtask

    task automatic test_bypass();
        set_in(2'b00, 0, 0, 0, 1'b1); advance();
        set_in(2'b11, 60, 61, 2, 1'b0);
        #1;
`ifdef DECODE_RENAME_BYPASS_EN
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL byp_valid got %b want 11", out_valid); end
        checks++; if (out_data[DW-1:0] !== pay(60)) begin errors++; $display("FAIL byp_slot0 got %h want %h", out_data[DW-1:0], pay(60)); end
        checks++; if (out_data[2*DW-1:DW] !== pay(61)) begin errors++; $display("FAIL byp_slot1 got %h want %h", out_data[2*DW-1:DW], pay(61)); end
`else
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL nobyp_valid got %b want 00", out_valid); end
`endif
        advance();
        set_in(2'b00, 0, 0, 0, 1'b0);
        #1;
`ifdef DECODE_RENAME_BYPASS_EN
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL byp_count got %0d want 0", count); end
`else
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL nobyp_count got %0d want 2", count); end
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL nobyp_valid_next got %b want 11", out_valid); end
        checks++; if (out_data[DW-1:0] !== pay(60)) begin errors++; $display("FAIL nobyp_slot0 got %h want %h", out_data[DW-1:0], pay(60)); end
`endif
        checks++; if (count !== 4'(sb.size())) begin errors++; $display("FAIL byp_model_count got %0d want %0d", count, sb.size()); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_noncontig_flush();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_rename_queue.md
Name: decode_rename_queue

Overview:
- Parametrised, WAY-wide in-order instruction queue between the decode stage and the rename stage.
- Replaces the fixed single-register, all-or-nothing enable stage with a circular buffer.
- Accepts up to WAY decoded instructions per cycle and releases up to WAY per cycle.
- Rename may consume fewer than offered (partial accept); the queue supports a pipeline flush.

Parameters:
- WAY, 2, instructions enqueued/dequeued per cycle (1..4)
- DW, 165, payload bits per instruction (pc, prediction, decode controls, regs, imm, next_pc, split/valid flags)
- DEPTH, 8, entry count; power of two, DEPTH >= 2*WAY

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all entries
- in_valid  in  WAY  per-slot valid from decode; slot 0 is oldest
- in_data  in  WAY*DW  slot i at bits [i*DW +: DW]
- in_ready  out  1  queue can take a full WAY group this cycle
- out_valid  out  WAY  per-slot valid toward rename; slot 0 is oldest
- out_data  out  WAY*DW  oldest min(count,WAY) entries, same packing as in_data
- out_accept  in  $clog2(WAY+1)  number of out slots rename consumes this cycle
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage: DEPTH x DW register array; head, tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count register.
- Reset (reset=0, async): head=0, tail=0, count=0. Outputs: out_valid=0, in_ready=1, count=0. out_data is don't-care but must not be X-propagating into out_valid. Storage is not cleared.
- in_valid contiguity:
  - nin = number of contiguous 1s from bit 0.
  - Bits above the first 0 are ignored and not enqueued.
- Enqueue:
  - Occurs when in_ready=1 and nin>0.
  - Slot i is written to (tail+i) mod DEPTH; tail += nin.
  - When in_ready=0, inputs are ignored; decode holds its group.
- in_ready: combinational from registered count, equal to (DEPTH - count) >= WAY. It does not depend on same-cycle dequeue.
- Output:
  - out_valid[i] = (i < count); out_data slot i = entry (head+i) mod DEPTH.
  - Purely a function of registered state (no input-to-output path, unless the optional feature is enabled).
  - Minimum latency from enqueue to visibility is 1 cycle.
- Dequeue:
  - nacc = min(out_accept, count, WAY); head += nacc.
  - out_accept larger than the available count is clamped, not an error.
- Simultaneous enqueue and dequeue: count_next = count + nin_eff - nacc. Both pointers update in the same edge.
- Flush:
  - Highest priority. On a flush edge, head=tail=0 and count=0.
  - Same-cycle enqueue and dequeue are discarded (no pointer movement from them).
  - in_ready remains per the formula (still derived from pre-flush count) during the flush cycle.
- Full: count=DEPTH gives in_ready=0. Partially full with free < WAY also gives in_ready=0 (group is never split).
- Empty: count=0 gives out_valid=0; out_accept is ignored.
- Wrap: pointer arithmetic in log2(DEPTH) bits. Ordering is preserved across wrap; count distinguishes full from empty.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries are lost.
- Assertions (sim only): count <= DEPTH; out_accept <= popcount(out_valid) is flagged as a warning.

Optional Feature:
- Macro: DECODE_RENAME_BYPASS_EN.
- Defined:
  - When count < WAY and flush=0, free out slots j >= count are filled combinationally from in_data slots (j - count), with out_valid set accordingly. This gives 0-cycle latency.
  - Entries accepted in that same cycle via bypass are not written; tail advances only by the non-consumed incoming entries.
  - count_next is computed as before on the merged view.
- Not defined: outputs come from storage only; entries become visible 1 cycle after enqueue.

Test Plan:
- Reset: hold reset=0 3 cycles, release → count=0, out_valid=0, in_ready=1; pulse reset=0 mid-traffic at count=5 → count=0 immediately.
- Fill (WAY=2, DEPTH=8): in_valid=11 for 4 cycles, out_accept=0 → count=8, in_ready=0; 5th group ignored; out_data slot0 = first enqueued payload.
- Wrap/order: stream payloads 0..23 two per cycle, out_accept=1 every cycle → rename sees 0,1,2,...,23 in order across 3 pointer wraps; no duplicates or drops.
- Simultaneous/partial: count=3 (A,B,C); in_valid=11 (D,E), out_accept=2 → next count=3, out slot0=C, slot1=D; in_valid=01 with out_accept=3 → nacc clamps to 2.
- Non-contiguous/flush: in_valid=10 → nothing enqueued. count=6, flush=1 with in_valid=11 and out_accept=2 → next count=0, out_valid=00, subsequent enqueue lands at index 0.
- Bypass: empty queue, in_valid=11 (X,Y), out_accept=2 → with DECODE_RENAME_BYPASS_EN, same-cycle out_valid=11 (X,Y) and count stays 0; without it, out_valid=00 then 11 next cycle, count=2.
